// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  // Writeback result source select.
  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2,
    RES_AUX  = 2'd3
  } result_src_e;

  // Load funct3 encodings.
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/wb_lu_if.sv
// Valid/ready handoff from the long-latency unit (mul/div) into the writeback buffer.
interface wb_lu_if #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
);
  logic               lu_valid;
  logic [A_WIDTH-1:0] lu_rd;
  logic [D_WIDTH-1:0] lu_data;
  logic               lu_ready;
  logic               lu_pending;

  // Long-latency unit side: offers results.
  modport master (
    output lu_valid, lu_rd, lu_data,
    input  lu_ready, lu_pending
  );

  // Writeback stage side: accepts results into its buffer.
  modport slave (
    input  lu_valid, lu_rd, lu_data,
    output lu_ready, lu_pending
  );
endinterface

// File: rtl/load_extend.sv
// Extracts a byte/half/word from an aligned memory word and sign/zero extends it.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; half lanes ignore offset[0] (misalignment is not trapped here).
  always_comb begin
    byte_s = 8'h00;
    case (offset)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extension by load type; unknown codes pass the full word.
  always_comb begin
    ext = word;
    case (funct3)
      LD_B:    ext = {{24{byte_s[7]}}, byte_s};
      LD_BU:   ext = {24'h000000, byte_s};
      LD_H:    ext = {{16{half_s[15]}}, half_s};
      LD_HU:   ext = {16'h0000, half_s};
      LD_W:    ext = word;
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register, result select, and register-file write-port arbitration
// between the in-order pipeline and a buffered long-latency unit result.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5,
  parameter int SRC_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_w,
  input  logic               flush_w,
  input  logic               valid_m,
  input  logic               reg_write_m,
  input  logic [A_WIDTH-1:0] rd_m,
  input  logic [SRC_W-1:0]   result_src_m,
  input  logic [2:0]         load_type_m,
  input  logic [D_WIDTH-1:0] alu_result_m,
  input  logic [D_WIDTH-1:0] read_data_m,
  input  logic [D_WIDTH-1:0] pc_plus4_m,
  input  logic [D_WIDTH-1:0] aux_m,
  wb_lu_if.slave             lu,
  output logic               reg_write_w,
  output logic [A_WIDTH-1:0] rd_w,
  output logic [D_WIDTH-1:0] result_w
);

  // WB pipeline register
  logic               valid_r;
  logic               reg_write_r;
  logic [A_WIDTH-1:0] rd_r;
  logic [SRC_W-1:0]   src_r;
  logic [2:0]         ltype_r;
  logic [D_WIDTH-1:0] alu_r;
  logic [D_WIDTH-1:0] rdata_r;
  logic [D_WIDTH-1:0] pc4_r;
  logic [D_WIDTH-1:0] aux_r;

  // Long-latency result buffer
  logic               buf_valid_r;
  logic [A_WIDTH-1:0] buf_rd_r;
  logic [D_WIDTH-1:0] buf_data_r;

  logic [D_WIDTH-1:0] load_s;
  logic [D_WIDTH-1:0] wb_result_s;
  logic               pipe_wr_s;
  logic               drain_s;
  logic               kill_s;
  logic               accept_s;

  // WB register: flush beats stall; flush only invalidates, payload is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= {A_WIDTH{1'b0}};
      src_r       <= {SRC_W{1'b0}};
      ltype_r     <= 3'b000;
      alu_r       <= {D_WIDTH{1'b0}};
      rdata_r     <= {D_WIDTH{1'b0}};
      pc4_r       <= {D_WIDTH{1'b0}};
      aux_r       <= {D_WIDTH{1'b0}};
    end else if (flush_w) begin
      valid_r <= 1'b0;
    end else if (!stall_w) begin
      valid_r     <= valid_m;
      reg_write_r <= reg_write_m;
      rd_r        <= rd_m;
      src_r       <= result_src_m;
      ltype_r     <= load_type_m;
      alu_r       <= alu_result_m;
      rdata_r     <= read_data_m;
      pc4_r       <= pc_plus4_m;
      aux_r       <= aux_m;
    end
  end

  load_extend u_load_extend (
    .word   (rdata_r),
    .offset (alu_r[1:0]),
    .funct3 (ltype_r),
    .ext    (load_s)
  );

  // Result select from the registered instruction.
  always_comb begin
    wb_result_s = alu_r;
    case (src_r)
      RES_ALU:  wb_result_s = alu_r;
      RES_LOAD: wb_result_s = load_s;
      RES_PC4:  wb_result_s = pc4_r;
      RES_AUX:  wb_result_s = aux_r;
      default:  wb_result_s = alu_r;
    endcase
  end

  // Arbitration terms: pipeline wins; a same-rd pipeline write kills the stale buffer.
  always_comb begin
    pipe_wr_s = valid_r & reg_write_r & (rd_r != {A_WIDTH{1'b0}});
    drain_s   = buf_valid_r & ~pipe_wr_s;
    kill_s    = buf_valid_r & pipe_wr_s & (rd_r == buf_rd_r);
    accept_s  = lu.lu_valid & ~buf_valid_r;
  end

  // Buffer: loads on accept (x0 results discarded), clears on drain or kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_r <= 1'b0;
      buf_rd_r    <= {A_WIDTH{1'b0}};
      buf_data_r  <= {D_WIDTH{1'b0}};
    end else if (accept_s) begin
      buf_valid_r <= (lu.lu_rd != {A_WIDTH{1'b0}});
      buf_rd_r    <= lu.lu_rd;
      buf_data_r  <= lu.lu_data;
    end else if (drain_s || kill_s) begin
      buf_valid_r <= 1'b0;
    end
  end

  // Write port mux and handshake outputs.
  always_comb begin
    lu.lu_ready   = ~buf_valid_r;
    lu.lu_pending = buf_valid_r;
    reg_write_w   = pipe_wr_s | buf_valid_r;
    if (drain_s) begin
      rd_w     = buf_rd_r;
      result_w = buf_data_r;
    end else begin
      rd_w     = rd_r;
      result_w = wb_result_s;
    end
  end

endmodule
